// File: rtl/frame_buffer_reader_pkg.sv
// Shared types and raster helpers for the 1bpp frame buffer scan-out path.
package frame_buffer_reader_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, SCAN} state_t;

    localparam int DEF_H_ACTIVE   = 800;
    localparam int DEF_H_BLANK    = 160;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_BLANK    = 45;
    localparam int DEF_RD_LATENCY = 1;

    function automatic int h_total(input int h_active, input int h_blank);
        return h_active + h_blank;
    endfunction

    function automatic int v_total(input int v_active, input int v_blank);
        return v_active + v_blank;
    endfunction

    // 16 pixels per RAM word
    function automatic int wpl(input int h_active);
        return h_active / 16;
    endfunction

endpackage

// File: rtl/frame_buffer_reader_raster.sv
// Free-running h/v raster counter with wrap and active-region flags.
module raster_counter
    import frame_buffer_reader_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_BLANK  = DEF_V_BLANK,
    parameter int H_START  = 0,
    parameter int V_START  = 0,
    parameter int HW       = $clog2(h_total(H_ACTIVE, H_BLANK)),
    parameter int VW       = $clog2(v_total(V_ACTIVE, V_BLANK))
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          h_act,
    output logic          v_act,
    output logic          frame_end
);
    localparam logic [HW-1:0] H_LAST = HW'(h_total(H_ACTIVE, H_BLANK) - 1);
    localparam logic [VW-1:0] V_LAST = VW'(v_total(V_ACTIVE, V_BLANK) - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_INIT = HW'(H_START);
    localparam logic [VW-1:0] V_INIT = VW'(V_START);

    // Stopped counters park at the start position so a restart is deterministic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h <= H_INIT;
            v <= V_INIT;
        end else if (!run) begin
            h <= H_INIT;
            v <= V_INIT;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign h_act     = (h < H_ACT);
    assign v_act     = (v < V_ACT);
    assign frame_end = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/frame_buffer_reader.sv
// Frame buffer scan-out: waits for the writer, fetches 16-pixel words and
// serializes them MSB-first with blanking and frame/line markers.
module frame_buffer_reader
    import frame_buffer_reader_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_BLANK    = DEF_V_BLANK,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        buf_busy,
    output logic [15:0] address,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        pixel,
    output logic        de,
    output logic        hblank,
    output logic        vblank,
    output logic        frame_start,
    output logic        line_start
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_BLANK);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_BLANK);
    localparam int WPL     = wpl(H_ACTIVE);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_PREF     = HW'(H_TOTAL - 16);
    localparam logic [HW-1:0] H_LAST_RD  = HW'(H_ACTIVE - 16);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [15:0]   LAST_WORD  = 16'(V_ACTIVE * WPL - 1);

    state_t              state, state_nxt;
    logic [HW-1:0]       h;
    logic [VW-1:0]       v;
    logic                h_act, v_act, frame_end;
    logic                go, cont, last_line, scan, act, issue;
    logic [RD_LATENCY:0] vld_pipe;
    logic [15:0]         hold, shifter;

    assign go        = enable & ~buf_busy;
    assign last_line = (v == V_LAST);
    assign scan      = (state == SCAN);
    assign act       = scan & h_act & v_act;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK),
        .H_START  (H_TOTAL - 17),
        .V_START  (V_TOTAL - 1)
    ) u_raster (
        .clk       (clk),
        .reset     (reset),
        .run       (state != IDLE),
        .h         (h),
        .v         (v),
        .h_act     (h_act),
        .v_act     (v_act),
        .frame_end (frame_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = PRIME;
            PRIME:   if (frame_end) state_nxt = SCAN;
            SCAN:    if (frame_end && !cont) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In-line reads fetch the following word; the blank-time read prefetches
    // word 0 of the next active line, gated by go on the last frame line.
    always_comb begin
        issue = 1'b0;
        if (scan && v_act && (h < H_LAST_RD) && (h[3:0] == 4'd0))
            issue = 1'b1;
        if ((h == H_PREF) && (last_line || (v < V_ACT_LAST)) &&
            ((state == PRIME) || (scan && (!last_line || go))))
            issue = 1'b1;
    end

    // Continue/stop decision is frozen with the prefetch so the two never disagree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cont <= 1'b0;
        else if (scan && last_line && (h == H_PREF))
            cont <= go;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de          <= 1'b0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            address     <= '0;
        end else begin
            de          <= act;
            hblank      <= scan & ~h_act;
            vblank      <= scan & ~v_act;
            frame_start <= scan && (h == '0) && (v == '0);
            line_start  <= scan && (h == '0) && v_act;
            if (state == IDLE)
                address <= '0;
            else if (rd_en)
                address <= (address == LAST_WORD) ? '0 : address + 16'd1;
        end
    end

    // vld_pipe[0] is the read strobe itself; the tap RD_LATENCY later marks valid data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[RD_LATENCY-1:0], issue};
    end
    assign rd_en = vld_pipe[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold    <= '0;
            shifter <= '0;
        end else begin
            if (vld_pipe[RD_LATENCY])
                hold <= rd_data;
            if (act && (h[3:0] == 4'd0))
                shifter <= hold;
            else if (act)
                shifter <= {shifter[14:0], 1'b0};
            else
                shifter <= '0;
        end
    end
    assign pixel = shifter[15];

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench: small raster, RAM word[a] = {a[7:0], ~a[7:0]}, two read latencies.
module tb_frame_buffer_reader;
    localparam int HA = 32, HB = 16, VA = 4, VB = 2;
    localparam int HT = HA + HB, VT = VA + VB, WPL = HA / 16;

    logic clk = 1'b0, reset = 1'b0, enable = 1'b0, buf_busy = 1'b0;
    logic [15:0] address, address14, rd_data, rd_data14;
    logic rd_en, pixel, de, hblank, vblank, frame_start, line_start;
    logic rd_en14, pixel14, de14, hblank14, vblank14, fs14, ls14;

    int n_vec = 0, n_err = 0, cyc = 0;
    logic [15:0] rd_log[$];
    int          rd_cyc[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    logic [15:0] ram1;
    logic [15:0] ram14 [1:14];
    always @(posedge clk) ram1 <= rd_en ? word(address) : 16'hA5A5;
    always @(posedge clk) begin
        ram14[1] <= rd_en14 ? word(address14) : 16'hA5A5;
        for (int k = 2; k <= 14; k++) ram14[k] <= ram14[k-1];
    end
    assign rd_data   = ram1;
    assign rd_data14 = ram14[14];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            rd_log.push_back(address);
            rd_cyc.push_back(cyc);
        end
    end

    frame_buffer_reader #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .buf_busy(buf_busy),
        .address(address), .rd_en(rd_en), .rd_data(rd_data), .pixel(pixel), .de(de),
        .hblank(hblank), .vblank(vblank), .frame_start(frame_start), .line_start(line_start));

    frame_buffer_reader #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .RD_LATENCY(14)) dut14 (
        .clk(clk), .reset(reset), .enable(enable), .buf_busy(buf_busy),
        .address(address14), .rd_en(rd_en14), .rd_data(rd_data14), .pixel(pixel14), .de(de14),
        .hblank(hblank14), .vblank(vblank14), .frame_start(fs14), .line_start(ls14));

    // Waits (bounded) for frame_start, then checks every cycle of the frame line by line.
    task automatic check_frame(input string tag, input int budget, input int busy_line);
        logic [HT-1:0] de_v, hb_v, vb_v, ls_v, fs_v, px_v, px14_v;
        logic [HT-1:0] e_de, e_hb, e_vb, e_ls, e_fs, e_px;
        logic [15:0] wd;
        int lat;
        @(negedge clk);
        lat = 1;
        while (!frame_start && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (!frame_start) begin
            $display("FAIL %s frame_start: not seen after %0d cycles, required within %0d", tag, lat, budget);
            n_err++;
            return;
        end
        for (int l = 0; l < VT; l++) begin
            for (int i = 0; i < HT; i++) begin
                if (!(l == 0 && i == 0)) @(negedge clk);
                if (l == busy_line && i == 0) buf_busy = 1'b1;
                de_v[i] = de; hb_v[i] = hblank; vb_v[i] = vblank;
                ls_v[i] = line_start; fs_v[i] = frame_start;
                px_v[i] = pixel; px14_v[i] = pixel14;
                wd = word(16'(l * WPL + i / 16));
                e_de[i] = (l < VA) && (i < HA);
                e_hb[i] = (i >= HA);
                e_vb[i] = (l >= VA);
                e_ls[i] = (l < VA) && (i == 0);
                e_fs[i] = (l == 0) && (i == 0);
                e_px[i] = ((l < VA) && (i < HA)) ? wd[15 - (i % 16)] : 1'b0;
            end
            n_vec++;
            if (de_v !== e_de || hb_v !== e_hb || vb_v !== e_vb || ls_v !== e_ls || fs_v !== e_fs) begin
                $display("FAIL %s line %0d markers: got de=%h hb=%h vb=%h ls=%h fs=%h, want de=%h hb=%h vb=%h ls=%h fs=%h",
                         tag, l, de_v, hb_v, vb_v, ls_v, fs_v, e_de, e_hb, e_vb, e_ls, e_fs);
                n_err++;
            end
            n_vec++;
            if (px_v !== e_px) begin
                $display("FAIL %s line %0d pixels_lat1: got %h, want %h", tag, l, px_v, e_px);
                n_err++;
            end
            n_vec++;
            if (px14_v !== e_px) begin
                $display("FAIL %s line %0d pixels_lat14: got %h, want %h", tag, l, px14_v, e_px);
                n_err++;
            end
        end
    endtask

    // Expects addresses 0..WPL*VA-1 in order, optionally followed by the next-frame prefetch of 0.
    task automatic check_reads(input string tag, input bit trailing);
        int exp_n, min_gap;
        bit ok;
        string got;
        exp_n = VA * WPL + (trailing ? 1 : 0);
        ok = (rd_log.size() == exp_n);
        got = "";
        foreach (rd_log[k]) got = {got, $sformatf(" %0d", rd_log[k])};
        if (ok)
            for (int k = 0; k < exp_n; k++)
                if (rd_log[k] !== 16'((k < VA * WPL) ? k : 0)) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            $display("FAIL %s rd_seq: got [%s ], want 0..%0d%s", tag, got, VA * WPL - 1, trailing ? " then 0" : "");
            n_err++;
        end
        min_gap = 1000;
        for (int k = 1; k < rd_cyc.size(); k++)
            if (rd_cyc[k] - rd_cyc[k-1] < min_gap) min_gap = rd_cyc[k] - rd_cyc[k-1];
        n_vec++;
        if (min_gap < 16) begin
            $display("FAIL %s rd_spacing: got min gap %0d, want >= 16", tag, min_gap);
            n_err++;
        end
        repeat (VA * WPL) if (rd_log.size() > 0) begin
            void'(rd_log.pop_front());
            void'(rd_cyc.pop_front());
        end
    endtask

    task automatic test_reset();
        logic [22:0] acc;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({address, rd_en, pixel, de, hblank, vblank, frame_start, line_start} !== 23'd0) begin
            $display("FAIL reset_state: got %h, want 0", {address, rd_en, pixel, de, hblank, vblank, frame_start, line_start});
            n_err++;
        end
        reset = 1'b1;
        acc = '0;
        repeat (20) begin
            @(negedge clk);
            acc |= {address, rd_en, pixel, de, hblank, vblank, frame_start, line_start};
        end
        n_vec++;
        if (acc !== 23'd0) begin
            $display("FAIL idle_disabled: got OR of outputs %h, want 0", acc);
            n_err++;
        end
    endtask

    task automatic test_writer_handshake();
        logic [3:0] acc;
        rd_log.delete();
        rd_cyc.delete();
        buf_busy = 1'b1;
        enable   = 1'b1;
        acc = '0;
        repeat (100) begin
            @(negedge clk);
            acc |= {rd_en, de, pixel, frame_start};
        end
        n_vec++;
        if (acc !== 4'd0) begin
            $display("FAIL busy_hold: got OR of rd_en/de/pixel/fs %b, want 0000", acc);
            n_err++;
        end
        buf_busy = 1'b0;
        check_frame("handshake", HT + 16, -1);
        check_reads("handshake", 1'b1);
    endtask

    task automatic test_back_to_back();
        check_frame("b2b", 1, -1);
        check_reads("b2b", 1'b1);
    endtask

    task automatic test_mid_frame_busy();
        logic [6:0] acc;
        check_frame("midbusy", 1, 2);
        check_reads("midbusy", 1'b0);
        acc = '0;
        repeat (40) begin
            @(negedge clk);
            acc |= {rd_en, de, hblank, vblank, frame_start, line_start, pixel};
        end
        n_vec++;
        if (acc !== 7'd0) begin
            $display("FAIL midbusy_idle: got OR of outputs %b, want 0", acc);
            n_err++;
        end
        buf_busy = 1'b0;
        check_frame("restart", HT + 16, -1);
        check_reads("restart", 1'b1);
    endtask

    task automatic test_async_reset();
        logic [45:0] outs;
        logic acc;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < HT * VT + 2);
        repeat (HT + 10) @(negedge clk);
        #2 reset = 1'b0;
        #1 outs = {address, rd_en, pixel, de, hblank, vblank, frame_start, line_start,
                   address14, rd_en14, pixel14, de14, hblank14, vblank14, fs14, ls14};
        n_vec++;
        if (outs !== 46'd0) begin
            $display("FAIL async_reset_outputs: got %h, want 0", outs);
            n_err++;
        end
        rd_log.delete();
        rd_cyc.delete();
        acc = 1'b0;
        repeat (10) begin
            @(negedge clk);
            acc |= rd_en | rd_en14;
        end
        n_vec++;
        if (acc !== 1'b0) begin
            $display("FAIL reset_no_read: got rd_en %b during reset, want 0", acc);
            n_err++;
        end
        reset = 1'b1;
        check_frame("post_reset", HT + 16, -1);
        check_reads("post_reset", 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_writer_handshake();
        test_back_to_back();
        test_mid_frame_busy();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
